// File: rtl/button_event_queue.sv
// Turns debouncer change snapshots into an ordered stream of {index, state} events.
// Events are buffered in a show-ahead FIFO with an IRQ level and a sticky overflow flag.
module button_event_queue #(
  parameter int MUX_ADDR_BITS   = 4,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                          CLK,
  input  logic                          RESETN,
  input  logic [(1<<MUX_ADDR_BITS)-1:0] DEBOUNCED,
  input  logic [(1<<MUX_ADDR_BITS)-1:0] CHANGE_FLAGS,
  input  logic                          UPDATED,
  input  logic                          EVENT_RD,
  output logic                          EVENT_VALID,
  output logic [MUX_ADDR_BITS-1:0]      EVENT_INDEX,
  output logic                          EVENT_STATE,
  output logic [FIFO_DEPTH_BITS:0]      EVENT_COUNT,
  output logic                          OVERFLOW,
  input  logic                          OVERFLOW_CLEAR,
  output logic                          BUSY,
  output logic                          IRQ
);

  localparam int N  = 1 << MUX_ADDR_BITS;
  localparam int D  = 1 << FIFO_DEPTH_BITS;
  localparam int EW = MUX_ADDR_BITS + 1;
  localparam int CW = FIFO_DEPTH_BITS + 1;
  localparam int PW = FIFO_DEPTH_BITS;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                   state_reg, state_next;
  logic [MUX_ADDR_BITS-1:0] idx_reg, idx_next;
  logic [N-1:0]             pend_flags_reg, pend_flags_next;
  logic [N-1:0]             pend_vals_reg, pend_vals_next;
  logic [N-1:0]             nxt_flags_reg, nxt_flags_next;
  logic [N-1:0]             nxt_vals_reg, nxt_vals_next;
  logic                     nxt_valid_reg, nxt_valid_next;

  logic                     capture;
  logic                     scan_last;
  logic                     push_req;
  logic [EW-1:0]            push_data;

  logic [EW-1:0]            mem [D];
  logic [PW-1:0]            wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]            rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]            count_reg, count_next;
  logic [EW-1:0]            head_reg, head_next;
  logic                     overflow_reg, overflow_next;
  logic                     irq_reg;
  logic                     fifo_full;
  logic                     pop_ok;
  logic                     push_ok;

  assign capture   = UPDATED && (CHANGE_FLAGS != '0);
  assign scan_last = (idx_reg == MUX_ADDR_BITS'(N - 1));
  assign push_req  = (state_reg == SCAN) && pend_flags_reg[idx_reg];
  assign push_data = {idx_reg, pend_vals_reg[idx_reg]};

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg      <= IDLE;
      idx_reg        <= '0;
      pend_flags_reg <= '0;
      pend_vals_reg  <= '0;
      nxt_flags_reg  <= '0;
      nxt_vals_reg   <= '0;
      nxt_valid_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      pend_flags_reg <= pend_flags_next;
      pend_vals_reg  <= pend_vals_next;
      nxt_flags_reg  <= nxt_flags_next;
      nxt_vals_reg   <= nxt_vals_next;
      nxt_valid_reg  <= nxt_valid_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    pend_flags_next = pend_flags_reg;
    pend_vals_next  = pend_vals_reg;
    nxt_flags_next  = nxt_flags_reg;
    nxt_vals_next   = nxt_vals_reg;
    nxt_valid_next  = nxt_valid_reg;
    case (state_reg)
      IDLE: begin
        if (capture) begin
          state_next      = SCAN;
          idx_next        = '0;
          pend_flags_next = CHANGE_FLAGS;
          pend_vals_next  = DEBOUNCED;
        end
      end
      SCAN: begin
        idx_next = idx_reg + MUX_ADDR_BITS'(1);
        if (scan_last) begin
          // An update arriving in the wrap cycle joins the transfer so nothing is stranded
          if (nxt_valid_reg || capture) begin
            state_next      = SCAN;
            pend_flags_next = nxt_flags_reg | (capture ? CHANGE_FLAGS : '0);
            pend_vals_next  = capture ? DEBOUNCED : nxt_vals_reg;
            nxt_flags_next  = '0;
            nxt_valid_next  = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else if (capture) begin
          nxt_flags_next = nxt_flags_reg | CHANGE_FLAGS;
          nxt_vals_next  = DEBOUNCED;
          nxt_valid_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fifo_full = (count_reg == CW'(D));
  assign pop_ok    = EVENT_RD && (count_reg != '0);
  assign push_ok   = push_req && (!fifo_full || pop_ok);

  always_comb begin
    wr_ptr_next   = wr_ptr_reg + (push_ok ? PW'(1) : PW'(0));
    rd_ptr_next   = rd_ptr_reg + (pop_ok ? PW'(1) : PW'(0));
    count_next    = count_reg + CW'(push_ok) - CW'(pop_ok);
    // Head register is refreshed from the RAM, or bypassed when the push lands in an empty FIFO
    head_next     = head_reg;
    if (count_reg > CW'(pop_ok))
      head_next = mem[rd_ptr_next];
    else if (push_ok)
      head_next = push_data;
    overflow_next = overflow_reg;
    if (push_req && !push_ok)
      overflow_next = 1'b1;
    else if (OVERFLOW_CLEAR)
      overflow_next = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (push_ok)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      head_reg     <= '0;
      overflow_reg <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      head_reg     <= head_next;
      overflow_reg <= overflow_next;
      irq_reg      <= (count_reg != '0);
    end
  end

  assign EVENT_VALID = (count_reg != '0);
  assign EVENT_INDEX = head_reg[EW-1:1];
  assign EVENT_STATE = head_reg[0];
  assign EVENT_COUNT = count_reg;
  assign OVERFLOW    = overflow_reg;
  assign BUSY        = (state_reg == SCAN);
  assign IRQ         = irq_reg;

endmodule
